// File: rtl/id_pkg.sv
// Shared types and ASCII bounds for the identifier token controller.
package id_pkg;

  typedef enum logic [1:0] {StIdle, StInId, StSkip} state_e;

  typedef enum logic [1:0] {ClsLetter, ClsDigit, ClsSep} char_class_e;

  localparam logic [7:0] AsciiDigitLo = 8'd48;
  localparam logic [7:0] AsciiDigitHi = 8'd57;
  localparam logic [7:0] AsciiUpperLo = 8'd65;
  localparam logic [7:0] AsciiUpperHi = 8'd90;
  localparam logic [7:0] AsciiLowerLo = 8'd97;
  localparam logic [7:0] AsciiLowerHi = 8'd122;

endpackage

// File: rtl/id_char_class.sv
// Combinational classifier: maps one ASCII byte to letter, digit or separator.
module id_char_class
  import id_pkg::*;
(
  input  logic [7:0]  char_i,
  output char_class_e cls_o
);

  logic is_upper, is_lower, is_digit;

  assign is_upper = (char_i >= AsciiUpperLo) && (char_i <= AsciiUpperHi);
  assign is_lower = (char_i >= AsciiLowerLo) && (char_i <= AsciiLowerHi);
  assign is_digit = (char_i >= AsciiDigitLo) && (char_i <= AsciiDigitHi);

  always_comb begin
    cls_o = ClsSep;
    if (is_upper || is_lower) begin
      cls_o = ClsLetter;
    end else if (is_digit) begin
      cls_o = ClsDigit;
    end
  end

endmodule

// File: rtl/id_token_ctrl.sv
// Identifier token controller: tracks letter-led alphanumeric runs and emits one
// buffered length record per identifier. Optional emit counter: ID_TOKEN_CNT_EN.
module id_token_ctrl
  import id_pkg::*;
#(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  input  logic             in_last,
  output logic             in_ready,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic [LEN_W-1:0] tok_len,
  output logic             tok_ovf,
  output logic [CNT_W-1:0] tok_cnt
);

  localparam logic [LEN_W-1:0] LenMax = '1;

  char_class_e      cls;
  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             tok_valid_q, tok_valid_d;
  logic [LEN_W-1:0] tok_len_q, tok_len_d;
  logic             tok_ovf_q, tok_ovf_d;
  logic             accept, emit;

  id_char_class u_char_class (
    .char_i (in_char),
    .cls_o  (cls)
  );

  assign in_ready = ~tok_valid_q | tok_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    tok_valid_d = tok_valid_q;
    tok_len_d   = tok_len_q;
    tok_ovf_d   = tok_ovf_q;
    emit        = 1'b0;

    if (tok_ready) begin
      tok_valid_d = 1'b0;
    end

    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (cls == ClsLetter) begin
            state_d = StInId;
            len_d   = LEN_W'(1);
            ovf_d   = 1'b0;
          end else if (cls == ClsDigit) begin
            state_d = StSkip;
          end
        end
        StInId: begin
          if (cls != ClsSep) begin
            // Length sticks at its maximum; the overflow flag records the loss.
            if (len_q == LenMax) begin
              ovf_d = 1'b1;
            end else begin
              len_d = len_q + LEN_W'(1);
            end
          end else begin
            emit    = 1'b1;
            state_d = StIdle;
          end
        end
        StSkip: begin
          if (cls == ClsSep) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase

      // End of stream closes an open identifier including this character.
      if (in_last) begin
        if (state_d == StInId) begin
          emit = 1'b1;
        end
        state_d = StIdle;
      end
    end

    if (emit) begin
      tok_valid_d = 1'b1;
      tok_len_d   = len_d;
      tok_ovf_d   = ovf_d;
      len_d       = '0;
      ovf_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      tok_valid_q <= 1'b0;
      tok_len_q   <= '0;
      tok_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      tok_valid_q <= tok_valid_d;
      tok_len_q   <= tok_len_d;
      tok_ovf_q   <= tok_ovf_d;
    end
  end

  assign tok_valid = tok_valid_q;
  assign tok_len   = tok_len_q;
  assign tok_ovf   = tok_ovf_q;

`ifdef ID_TOKEN_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d = emit ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tok_cnt = cnt_q;
`else
  assign tok_cnt = '0;
`endif

endmodule

// File: tb/tb_id_token_ctrl.sv
// Directed vector bench for id_token_ctrl, built with a 3-bit length field.
module tb_id_token_ctrl;

  localparam int unsigned LEN_W = 3;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [7:0]       in_char;
  logic             in_last;
  logic             in_ready;
  logic             tok_valid;
  logic             tok_ready;
  logic [LEN_W-1:0] tok_len;
  logic             tok_ovf;
  logic [CNT_W-1:0] tok_cnt;

  int checks   = 0;
  int failures = 0;
  int cnt_exp  = 0;

  id_token_ctrl #(
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_len   (tok_len),
    .tok_ovf   (tok_ovf),
    .tok_cnt   (tok_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] ch;
    logic       last;
    logic       rdy;
    logic       ir;    // expected in_ready before the edge
    logic       tv;    // expected tok_valid after the edge
    logic [2:0] len;
    logic       ovf;
    logic       emit;  // this edge produces a new record
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [7:0] ch, logic last, logic rdy, logic ir,
                              logic tv, logic [2:0] len, logic ovf, logic emit);
    vec_t t;
    t.v = v; t.ch = ch; t.last = last; t.rdy = rdy; t.ir = ir;
    t.tv = tv; t.len = len; t.ovf = ovf; t.emit = emit;
    return t;
  endfunction

  // Accepted plain character with tok_ready=1 and no record emitted.
  function automatic vec_t ch0(logic [7:0] ch);
    return mk(1'b1, ch, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
  endfunction

  function automatic vec_t idle();
    return mk(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input vec_t t, input string tag);
    @(negedge clk);
    in_valid  = t.v;
    in_char   = t.ch;
    in_last   = t.last;
    tok_ready = t.rdy;
    #1;
    check({tag, " in_ready"}, 32'(in_ready), 32'(t.ir));
    @(posedge clk);
    #1;
    if (t.emit) begin
`ifdef ID_TOKEN_CNT_EN
      cnt_exp = (cnt_exp + 1) % (1 << CNT_W);
`endif
    end
    check({tag, " tok_valid"}, 32'(tok_valid), 32'(t.tv));
    if (t.tv) begin
      check({tag, " tok_len"}, 32'(tok_len), 32'(t.len));
      check({tag, " tok_ovf"}, 32'(tok_ovf), 32'(t.ovf));
    end
    check({tag, " tok_cnt"}, 32'(tok_cnt), 32'(cnt_exp));
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    cnt_exp = 0;
    check({tag, " rst tok_valid"}, 32'(tok_valid), 32'd0);
    check({tag, " rst tok_len"}, 32'(tok_len), 32'd0);
    check({tag, " rst tok_ovf"}, 32'(tok_ovf), 32'd0);
    check({tag, " rst tok_cnt"}, 32'(tok_cnt), 32'd0);
    check({tag, " rst in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_char = 8'd0; in_last = 1'b0; tok_ready = 1'b0;
    repeat (2) @(posedge clk);
    pulse_reset("init");

    // "abc0 ": one record of length 4, held for exactly one cycle.
    vecs.push_back(ch0("a")); vecs.push_back(ch0("b"));
    vecs.push_back(ch0("c")); vecs.push_back(ch0("0"));
    vecs.push_back(mk(1, " ", 0, 1, 1, 1, 3'd4, 0, 1));
    vecs.push_back(idle());
    // "0a a1 ": the digit-led run yields nothing.
    vecs.push_back(ch0("0")); vecs.push_back(ch0("a")); vecs.push_back(ch0(" "));
    vecs.push_back(ch0("a")); vecs.push_back(ch0("1"));
    vecs.push_back(mk(1, " ", 0, 1, 1, 1, 3'd2, 0, 1));
    vecs.push_back(idle());
    // Nine letters saturate a 3-bit length, then a fresh "ab ".
    for (int i = 0; i < 9; i++) vecs.push_back(ch0("a"));
    vecs.push_back(mk(1, " ", 0, 1, 1, 1, 3'd7, 1, 1));
    vecs.push_back(ch0("a")); vecs.push_back(ch0("b"));
    vecs.push_back(mk(1, " ", 0, 1, 1, 1, 3'd2, 0, 1));
    vecs.push_back(idle());
    // "ab " then "c " with the consumer stalled for five cycles.
    vecs.push_back(ch0("a")); vecs.push_back(ch0("b"));
    vecs.push_back(mk(1, " ", 0, 1, 1, 1, 3'd2, 0, 1));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, "c", 0, 0, 0, 1, 3'd2, 0, 0));
    vecs.push_back(ch0("c"));
    vecs.push_back(mk(1, " ", 0, 1, 1, 1, 3'd1, 0, 1));
    vecs.push_back(idle());
    // in_last cases: lone letter, digit, letter run, separator, back-to-back emit.
    vecs.push_back(mk(1, "a", 1, 1, 1, 1, 3'd1, 0, 1));
    vecs.push_back(ch0("1")); vecs.push_back(ch0("b")); vecs.push_back(ch0(" "));
    vecs.push_back(mk(1, "5", 1, 1, 1, 0, 3'd0, 0, 0));
    vecs.push_back(ch0("q"));
    vecs.push_back(mk(1, " ", 0, 1, 1, 1, 3'd1, 0, 1));
    vecs.push_back(ch0("X"));
    vecs.push_back(mk(1, "y", 1, 1, 1, 1, 3'd2, 0, 1));
    vecs.push_back(ch0("Z"));
    vecs.push_back(mk(1, " ", 1, 1, 1, 1, 3'd1, 0, 1));
    vecs.push_back(ch0("p")); vecs.push_back(ch0("q"));
    vecs.push_back(mk(1, " ", 0, 1, 1, 1, 3'd2, 0, 1));
    vecs.push_back(mk(1, "k", 1, 1, 1, 1, 3'd1, 0, 1));
    vecs.push_back(idle());
    // Boundary characters around the letter and digit ranges are separators.
    vecs.push_back(ch0("@")); vecs.push_back(ch0("["));
    vecs.push_back(ch0(8'd96)); vecs.push_back(ch0("{"));
    vecs.push_back(ch0("/")); vecs.push_back(ch0(":"));
    vecs.push_back(ch0("z")); vecs.push_back(ch0("9")); vecs.push_back(ch0("A"));
    vecs.push_back(mk(1, "{", 0, 1, 1, 1, 3'd3, 0, 1));
    vecs.push_back(idle());

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-token: "ab" is dropped, "x " starts a new stream.
    step(ch0("a"), "rst_mid a");
    step(ch0("b"), "rst_mid b");
    pulse_reset("mid");
    step(ch0("x"), "rst_mid x");
    step(mk(1, " ", 0, 1, 1, 1, 3'd1, 0, 1), "rst_mid sep");
    // Reset with a stalled record pending.
    step(ch0("y"), "rst_pend y");
    step(mk(1, " ", 0, 0, 1, 1, 3'd1, 0, 1), "rst_pend sep");
    step(mk(1, "w", 0, 0, 0, 1, 3'd1, 0, 0), "rst_pend stall");
    pulse_reset("pend");
    step(mk(1, "w", 1, 0, 1, 1, 3'd1, 0, 1), "rst_pend w");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
